spi_frame_transmitter: RTL and testbench

Serializes a message of 16-bit words onto one outgoing SPI-style frame channel: TX_CLK, TX_DATA, TX_LOAD and TX_STOP. This is the transmit end of the same framing the redirector's SPI receive channels decode. It sits between a show-ahead word FIFO (Cypress-side write path) and one board SPI output. It is instantiated once per SPI channel, alongside the receive path.

---
 rtl/spi_tx_pkg.sv | 29 ++
 rtl/spi_bit_timer.sv | 32 +++
 rtl/spi_frame_transmitter.sv | 129 ++++++++++++
 tb/tb_spi_frame_transmitter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_tx_pkg.sv
// Shared types and constants for the SPI frame transmitter.
// Build option: SPI_TX_PARITY_EN appends an odd-parity bit after every word.
package spi_tx_pkg;

    localparam int WORD_W    = 16;
    localparam int LEN_W     = 8;
    localparam int BIT_CNT_W = 5;

`ifdef SPI_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        LOAD,
        STOP,
        GAP
    } state_t;

    // Bits shifted out per word, including the optional parity bit.
    function automatic int bit_count(input int word_w);
        return word_w + PAR_BITS;
    endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Bit-period timer: 2*CLK_DIV cycles per bit, held at phase 0 while hold is high.
module spi_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    output logic bit_start,
    output logic half
);

    localparam logic [8:0] LAST = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] MID  = 9'(CLK_DIV - 1);

    logic [8:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (hold || cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 9'd1;
        end
    end

    // bit_start: the closing edge of this cycle opens a new bit period.
    // half: the closing edge of this cycle is the rising serial clock edge.
    assign bit_start = !hold && (cnt_reg == LAST);
    assign half      = !hold && (cnt_reg == MID);

endmodule

// File: rtl/spi_frame_transmitter.sv
// Serializes a message of words from a show-ahead FIFO onto TX_CLK/TX_DATA/TX_LOAD/TX_STOP.
// Build option: SPI_TX_PARITY_EN adds one odd-parity bit after each word.
module spi_frame_transmitter #(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = spi_tx_pkg::WORD_W
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic [spi_tx_pkg::LEN_W-1:0] MSG_LEN,
    input  logic [WORD_W-1:0]            DATA,
    input  logic                         DATA_VALID,
    output logic                         DATA_RD,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         TX_CLK,
    output logic                         TX_DATA,
    output logic                         TX_LOAD,
    output logic                         TX_STOP
);

    import spi_tx_pkg::*;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(bit_count(WORD_W) - 1);

    state_t                 state_reg, state_next;
    logic [LEN_W-1:0]       words_reg;
    logic [WORD_W-1:0]      shift_reg;
    logic [BIT_CNT_W-1:0]   bit_reg;
    logic                   tx_clk_reg;
    logic                   hold;
    logic                   bit_start;
    logic                   half;
    logic                   data_bit;

    assign hold = (state_reg == IDLE) || (state_reg == FETCH);

    spi_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk       (CLK),
        .rst_n     (RST),
        .hold      (hold),
        .bit_start (bit_start),
        .half      (half)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        DATA_RD    = 1'b0;
        DONE       = 1'b0;
        case (state_reg)
            IDLE:  if (START && MSG_LEN != '0) state_next = FETCH;
            FETCH: if (DATA_VALID) begin
                       DATA_RD    = 1'b1;
                       state_next = SHIFT;
                   end
            SHIFT: if (bit_start && bit_reg == LAST_BIT) state_next = LOAD;
            LOAD:  if (bit_start) state_next = (words_reg == LEN_W'(1)) ? STOP : FETCH;
            STOP:  if (bit_start) state_next = GAP;
            GAP:   if (bit_start) begin
                       DONE       = 1'b1;
                       state_next = IDLE;
                   end
            default: state_next = IDLE;
        endcase
    end

`ifdef SPI_TX_PARITY_EN
    logic parity_reg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            parity_reg <= 1'b0;
        end else if (DATA_RD) begin
            parity_reg <= ~^DATA;
        end
    end

    assign data_bit = (bit_reg == BIT_CNT_W'(WORD_W)) ? parity_reg : shift_reg[WORD_W-1];
`else
    assign data_bit = shift_reg[WORD_W-1];
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            words_reg  <= '0;
            shift_reg  <= '0;
            bit_reg    <= '0;
            tx_clk_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && START) begin
                words_reg <= MSG_LEN;
            end else if (state_reg == LOAD && bit_start) begin
                words_reg <= words_reg - LEN_W'(1);
            end

            if (DATA_RD) begin
                shift_reg <= DATA;
                bit_reg   <= '0;
            end else if (state_reg == SHIFT && bit_start) begin
                shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
                bit_reg   <= bit_reg + BIT_CNT_W'(1);
            end

            // Serial clock only toggles while shifting, so LOAD/STOP/GAP stay low.
            if (state_reg == SHIFT && half) begin
                tx_clk_reg <= 1'b1;
            end else if (bit_start) begin
                tx_clk_reg <= 1'b0;
            end
        end
    end

    assign BUSY    = (state_reg != IDLE);
    assign TX_CLK  = tx_clk_reg;
    assign TX_DATA = (state_reg == SHIFT) && data_bit;
    assign TX_LOAD = (state_reg == LOAD);
    assign TX_STOP = (state_reg == STOP);

endmodule

// File: tb/tb_spi_frame_transmitter.sv
// Self-checking bench for spi_frame_transmitter: FIFO model, serial decoder and frame-level reference.
// Build option: SPI_TX_PARITY_EN switches the reference to expect a parity bit per word.
module tb_spi_frame_transmitter;

    localparam int D = 2;
`ifdef SPI_TX_PARITY_EN
    localparam int BITS = 17;
`else
    localparam int BITS = 16;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [7:0]  MSG_LEN;
    logic [15:0] DATA;
    logic        DATA_VALID;
    logic        DATA_RD, BUSY, DONE, TX_CLK, TX_DATA, TX_LOAD, TX_STOP;

    int n_assert = 0;
    int n_fail   = 0;

    // Show-ahead FIFO model: main process writes, feeder pops on DATA_RD.
    logic [15:0] mem [0:255];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    logic        stall;
    logic [15:0] exp_words [$];

    // Serial decoder state, owned by the monitor.
    logic [31:0] rx_sh = 32'd0;
    int          nbits = 0;
    logic [31:0] rx_words [$];
    int          rx_nb [$];
    logic        prev_clk = 1'b0, prev_load = 1'b0, prev_stop = 1'b0;
    int          rd_cnt = 0, ld_cnt = 0, st_cnt = 0, ld_hi = 0, st_hi = 0, dn_cnt = 0;

    always #5 CLK = ~CLK;

    spi_frame_transmitter #(
        .CLK_DIV (D),
        .WORD_W  (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .MSG_LEN    (MSG_LEN),
        .DATA       (DATA),
        .DATA_VALID (DATA_VALID),
        .DATA_RD    (DATA_RD),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .TX_CLK     (TX_CLK),
        .TX_DATA    (TX_DATA),
        .TX_LOAD    (TX_LOAD),
        .TX_STOP    (TX_STOP)
    );

    assign DATA       = mem[rd_ptr];
    assign DATA_VALID = (wr_ptr != rd_ptr) && !stall;

    always @(posedge CLK) begin
        if (DATA_RD === 1'b1) rd_ptr <= rd_ptr + 8'd1;
    end

    always @(negedge CLK) begin
        prev_clk  <= TX_CLK;
        prev_load <= TX_LOAD;
        prev_stop <= TX_STOP;
        if (RST !== 1'b1) begin
            rx_sh <= 32'd0;
            nbits <= 0;
        end else begin
            if (TX_CLK === 1'b1 && prev_clk === 1'b0) begin
                rx_sh <= {rx_sh[30:0], TX_DATA};
                nbits <= nbits + 1;
            end
            if (TX_LOAD === 1'b1 && prev_load === 1'b0) begin
                rx_words.push_back(rx_sh);
                rx_nb.push_back(nbits);
                rx_sh  <= 32'd0;
                nbits  <= 0;
                ld_cnt <= ld_cnt + 1;
            end
        end
        if (TX_LOAD === 1'b1) ld_hi <= ld_hi + 1;
        if (TX_STOP === 1'b1 && prev_stop === 1'b0) st_cnt <= st_cnt + 1;
        if (TX_STOP === 1'b1) st_hi <= st_hi + 1;
        if (DATA_RD === 1'b1) rd_cnt <= rd_cnt + 1;
        if (DONE === 1'b1) dn_cnt <= dn_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] serial_of(input logic [15:0] w);
`ifdef SPI_TX_PARITY_EN
        return {15'd0, w, ~^w};
`else
        return {16'd0, w};
`endif
    endfunction

    // Sends exp_words as one frame and checks it against frame-level expectations.
    task automatic run_frame(input bit underrun, input int restart_at, input string tag);
        int len, exp_cyc, cyc, rd0, ld0, st0, lh0, sh0, dn0, rx0, ustate, uc, clk_hi;
        logic seen_load;
        len = exp_words.size();
        exp_cyc = len * (1 + (BITS + 1) * 2 * D) + 4 * D + (underrun ? 20 : 0);
        rd0 = rd_cnt; ld0 = ld_cnt; st0 = st_cnt; lh0 = ld_hi; sh0 = st_hi; dn0 = dn_cnt;
        rx0 = rx_words.size();
        foreach (exp_words[i]) begin
            mem[wr_ptr] = exp_words[i];
            wr_ptr = wr_ptr + 8'd1;
        end
        stall = 1'b0;
        MSG_LEN = 8'(len);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        cyc = 1;
        chk({tag, "_busy_first"}, {31'd0, BUSY}, 32'd1);
        chk({tag, "_rd_first"}, {31'd0, DATA_RD}, 32'd1);
        ustate = 0; uc = 0; clk_hi = 0; seen_load = 1'b0;
        while (DONE !== 1'b1 && cyc < exp_cyc + 60) begin
            @(negedge CLK);
            cyc++;
            START = (cyc == restart_at);
            if (underrun) begin
                if (cyc == 2) stall = 1'b1;
                if (ustate == 0 && seen_load && TX_LOAD === 1'b0) ustate = 1;
                if (ustate == 1) begin
                    if (uc == 20) begin
                        stall = 1'b0;
                        ustate = 2;
                    end else begin
                        if (TX_CLK !== 1'b0) clk_hi++;
                        uc++;
                    end
                end
                seen_load = (TX_LOAD === 1'b1);
            end
        end
        START = 1'b0;
        stall = 1'b0;
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_busy_at_done"}, {31'd0, BUSY}, 32'd1);
        @(negedge CLK);
        chk({tag, "_busy_after"}, {31'd0, BUSY}, 32'd0);
        repeat (restart_at > 0 ? 100 : 3) @(negedge CLK);
        chk({tag, "_busy_idle"}, {31'd0, BUSY}, 32'd0);
        chk({tag, "_rd_pulses"}, 32'(rd_cnt - rd0), 32'(len));
        chk({tag, "_load_strobes"}, 32'(ld_cnt - ld0), 32'(len));
        chk({tag, "_stop_strobes"}, 32'(st_cnt - st0), 32'd1);
        chk({tag, "_load_cycles"}, 32'(ld_hi - lh0), 32'(len * 2 * D));
        chk({tag, "_stop_cycles"}, 32'(st_hi - sh0), 32'(2 * D));
        chk({tag, "_done_pulses"}, 32'(dn_cnt - dn0), 32'd1);
        if (underrun) chk({tag, "_clk_during_underrun"}, 32'(clk_hi), 32'd0);
        chk({tag, "_rx_count"}, 32'(rx_words.size() - rx0), 32'(len));
        for (int i = 0; i < len && rx0 + i < rx_words.size(); i++) begin
            chk({tag, "_word"}, rx_words[rx0 + i], serial_of(exp_words[i]));
            chk({tag, "_bits"}, 32'(rx_nb[rx0 + i]), 32'(BITS));
        end
        $display("frame %s len=%0d done_cycle=%0d", tag, len, cyc);
    endtask

    int n;
    int dn0, rd0;

    initial begin
        RST = 1'b0; START = 1'b0; MSG_LEN = 8'd0; stall = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", {25'd0, DATA_RD, BUSY, DONE, TX_CLK, TX_DATA, TX_LOAD, TX_STOP}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        exp_words = '{16'hA5C3};
        run_frame(1'b0, 0, "single");

        exp_words = '{16'h0001, 16'h8000, 16'hFFFF};
        run_frame(1'b0, 0, "multi");

        exp_words = '{16'h1357, 16'h2468, 16'h0003};
        run_frame(1'b1, 0, "underrun");

        dn0 = dn_cnt; rd0 = rd_cnt;
        MSG_LEN = 8'd0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("len0_busy", {31'd0, BUSY}, 32'd0);
        repeat (20) @(negedge CLK);
        chk("len0_busy_later", {31'd0, BUSY}, 32'd0);
        chk("len0_no_done", 32'(dn_cnt - dn0), 32'd0);
        chk("len0_no_rd", 32'(rd_cnt - rd0), 32'd0);
        $display("frame len0 ignored");

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 4);
            exp_words.delete();
            for (int k = 0; k < n; k++) exp_words.push_back(16'($urandom));
            run_frame(1'b0, 0, "random");
        end

        // Reset during bit 7 of word 1: bit 7 spans cycles 30..33, TX_CLK high from 32.
        dn0 = dn_cnt;
        mem[wr_ptr] = 16'hFFFF;
        wr_ptr = wr_ptr + 8'd1;
        MSG_LEN = 8'd1;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (31) @(negedge CLK);
        chk("pre_reset_clk", {31'd0, TX_CLK}, 32'd1);
        chk("pre_reset_data", {31'd0, TX_DATA}, 32'd1);
        RST = 1'b0;
        #1;
        chk("reset_midframe_outputs", {25'd0, DATA_RD, BUSY, DONE, TX_CLK, TX_DATA, TX_LOAD, TX_STOP}, 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (5) @(negedge CLK);
        chk("reset_no_done", 32'(dn_cnt - dn0), 32'd0);
        chk("reset_idle", {31'd0, BUSY}, 32'd0);
        $display("frame reset_midframe aborted");

        exp_words = '{16'h1234};
        run_frame(1'b0, 0, "after_reset");

        exp_words = '{16'h0003};
        run_frame(1'b0, 0, "parity_word");

        exp_words = '{16'h5A5A};
        run_frame(1'b0, 40, "start_busy");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
